// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the pipelined MIPS core front end.
//   REDIR_*   : 2-bit redirect select encodings driven by the decode stage
//   NOP_INSTR : encoding used for a bubble in the IF/ID register
//   XLEN/ID_W : native word width and the width of the IF/ID bundle
//               (instr + pc + pc4 + valid)
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [1:0] REDIR_NONE = 2'b00;
  localparam logic [1:0] REDIR_BR   = 2'b01;
  localparam logic [1:0] REDIR_J    = 2'b10;
  localparam logic [1:0] REDIR_JR   = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int XLEN = 32;
  localparam int ID_W = 3 * XLEN + 1;

endpackage : mips_pkg

// File: rtl/npc_sel.sv
// -----------------------------------------------------------------------------
// npc_sel
// Combinational next-PC selector for the fetch stage.
//   pc_i       : current fetch PC
//   id_pc4_i   : PC+4 of the instruction in ID (base for branch / j)
//   j_idx_i    : 26-bit instruction index field of the j/jal in ID
//   br_imm_i   : sign-extended branch offset, in words
//   jr_word_i  : jr target with the two byte-offset bits already dropped
//   sel_i      : redirect select (already qualified by ID valid)
//   npc_o      : next PC
// -----------------------------------------------------------------------------
module npc_sel
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] id_pc4_i,
  input  logic [25:0]       j_idx_i,
  input  logic [DATA_W-1:0] br_imm_i,
  input  logic [DATA_W-3:0] jr_word_i,
  input  logic [1:0]        sel_i,
  output logic [DATA_W-1:0] npc_o
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    npc_o = pc_i + DATA_W'(4);
    case (sel_i)
      REDIR_BR: npc_o = id_pc4_i + (br_imm_i << 2);
      REDIR_J:  npc_o = {id_pc4_i[DATA_W-1:28], j_idx_i, 2'b00};
      REDIR_JR: npc_o = {jr_word_i, 2'b00};
      default:  npc_o = pc_i + DATA_W'(4);
    endcase
  end

endmodule : npc_sel

// File: rtl/if_stage_p.sv
// -----------------------------------------------------------------------------
// if_stage_p
// Fetch stage: PC register, next-PC selection and the IF/ID register.
//   clk, rst      : clock; synchronous active-high reset
//   stall_i       : hold PC and IF/ID (load-use hazard)
//   flush_i       : load a bubble into IF/ID, PC still advances
//   redir_sel_i   : redirect from ID (none / branch / j / jr)
//   br_imm_i      : branch offset in words
//   jr_tgt_i      : jr target register value
//   im_addr_o     : instruction-memory word address (combinational from pc)
//   im_rdata_i    : instruction at im_addr_o, same cycle
//   id_instr_o, id_pc_o, id_pc4_o, id_valid_o : IF/ID register
//   misalign_o    : sticky flag, jr taken to a non word-aligned target
//   fetch_cnt_o   : saturating count of instructions accepted into IF/ID
//   bubble_cnt_o  : saturating count of bubbles inserted into IF/ID
// -----------------------------------------------------------------------------
module if_stage_p
  import mips_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              IM_AW    = 10,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [1:0]        redir_sel_i,
  input  logic [DATA_W-1:0] br_imm_i,
  input  logic [DATA_W-1:0] jr_tgt_i,
  output logic [IM_AW-1:0]  im_addr_o,
  input  logic [DATA_W-1:0] im_rdata_i,
  output logic [DATA_W-1:0] id_instr_o,
  output logic [DATA_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_pc4_o,
  output logic              id_valid_o,
  output logic              misalign_o,
  output logic [CNT_W-1:0]  fetch_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_id_instr;
  logic [DATA_W-1:0] r_id_pc;
  logic [DATA_W-1:0] r_id_pc4;
  logic              r_id_valid;
  logic              r_misalign;
  logic [CNT_W-1:0]  r_fetch_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic [1:0]        w_sel;
  logic              w_redir;
  logic              w_jr_misalign;
  logic [DATA_W-1:0] w_npc;
  logic [DATA_W-1:0] w_pc4;

  // A redirect only counts when ID holds a real instruction; a bubble in ID
  // must never steer the PC.
  assign w_sel         = r_id_valid ? redir_sel_i : REDIR_NONE;
  assign w_redir       = (w_sel != REDIR_NONE);
  assign w_jr_misalign = (w_sel == REDIR_JR) && (jr_tgt_i[1:0] != 2'b00);
  assign w_pc4         = r_pc + DATA_W'(4);

  npc_sel #(.DATA_W(DATA_W)) u_npc_sel (
    .pc_i      (r_pc),
    .id_pc4_i  (r_id_pc4),
    .j_idx_i   (r_id_instr[25:0]),
    .br_imm_i  (br_imm_i),
    .jr_word_i (jr_tgt_i[DATA_W-1:2]),
    .sel_i     (w_sel),
    .npc_o     (w_npc)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use <= so every flop samples pre-edge values.
    if (rst) begin
      r_pc         <= RESET_PC;
      r_id_instr   <= DATA_W'(NOP_INSTR);
      r_id_pc      <= '0;
      r_id_pc4     <= '0;
      r_id_valid   <= 1'b0;
      r_misalign   <= 1'b0;
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (!stall_i) begin
      r_pc <= w_npc;
      // The instruction fetched alongside a redirect is wrong-path.
      if (flush_i || w_redir) begin
        r_id_instr <= DATA_W'(NOP_INSTR);
        r_id_pc    <= '0;
        r_id_pc4   <= '0;
        r_id_valid <= 1'b0;
        if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end else begin
        r_id_instr <= im_rdata_i;
        r_id_pc    <= r_pc;
        r_id_pc4   <= w_pc4;
        r_id_valid <= 1'b1;
        if (r_fetch_cnt != '1) r_fetch_cnt <= r_fetch_cnt + 1'b1;
      end
      if (w_jr_misalign) r_misalign <= 1'b1;
    end
  end

  assign im_addr_o    = r_pc[IM_AW+1:2];
  assign id_instr_o   = r_id_instr;
  assign id_pc_o      = r_id_pc;
  assign id_pc4_o     = r_id_pc4;
  assign id_valid_o   = r_id_valid;
  assign misalign_o   = r_misalign;
  assign fetch_cnt_o  = r_fetch_cnt;
  assign bubble_cnt_o = r_bubble_cnt;

endmodule : if_stage_p

// File: tb/tb_if_stage_p.sv
// -----------------------------------------------------------------------------
// tb_if_stage_p
// Directed bench for if_stage_p. The instruction memory holds
// 0x2000_0000 + word index, except word 8 which holds a jal to index 0x40.
// Counters are built 5 bits wide so saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_if_stage_p;

  localparam int DATA_W = 32;
  localparam int IM_AW  = 10;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_i;
  logic              flush_i;
  logic [1:0]        redir_sel_i;
  logic [DATA_W-1:0] br_imm_i;
  logic [DATA_W-1:0] jr_tgt_i;
  logic [IM_AW-1:0]  im_addr_o;
  logic [DATA_W-1:0] im_rdata_i;
  logic [DATA_W-1:0] id_instr_o;
  logic [DATA_W-1:0] id_pc_o;
  logic [DATA_W-1:0] id_pc4_o;
  logic              id_valid_o;
  logic              misalign_o;
  logic [CNT_W-1:0]  fetch_cnt_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic [9:0]  addr;
    logic        mis;
    logic [4:0]  fc;
    logic [4:0]  bc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    if (a == 10'd8) return 32'h0C00_0040;
    return 32'h2000_0000 + {22'd0, a};
  endfunction

  assign im_rdata_i = mem_word(im_addr_o);

  if_stage_p #(
    .DATA_W(DATA_W), .IM_AW(IM_AW), .RESET_PC(32'h0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .redir_sel_i(redir_sel_i), .br_imm_i(br_imm_i), .jr_tgt_i(jr_tgt_i),
    .im_addr_o(im_addr_o), .im_rdata_i(im_rdata_i),
    .id_instr_o(id_instr_o), .id_pc_o(id_pc_o), .id_pc4_o(id_pc4_o),
    .id_valid_o(id_valid_o), .misalign_o(misalign_o),
    .fetch_cnt_o(fetch_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  // Expected state after an edge: IF/ID contents, fetch PC, flag and counts.
  function automatic exp_t mk(input logic v, input logic [31:0] idpc,
                              input logic [31:0] npc, input logic mis,
                              input int fc, input int bc);
    exp_t e;
    e.valid = v;
    e.pc    = v ? idpc : 32'h0;
    e.pc4   = v ? idpc + 32'd4 : 32'h0;
    e.instr = v ? mem_word(idpc[11:2]) : 32'h0;
    e.addr  = npc[11:2];
    e.mis   = mis;
    e.fc    = 5'(fc);
    e.bc    = 5'(bc);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f,
                      input logic [1:0] sel, input logic [31:0] bimm,
                      input logic [31:0] jt, input exp_t e);
    exp_t g;
    rst = r; stall_i = s; flush_i = f;
    redir_sel_i = sel; br_imm_i = bimm; jr_tgt_i = jt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("id_instr", id_instr_o, g.instr);
    chk("id_pc", id_pc_o, g.pc);
    chk("id_pc4", id_pc4_o, g.pc4);
    chk("id_valid", {31'd0, id_valid_o}, {31'd0, g.valid});
    chk("im_addr", {22'd0, im_addr_o}, {22'd0, g.addr});
    chk("misalign", {31'd0, misalign_o}, {31'd0, g.mis});
    chk("fetch_cnt", {27'd0, fetch_cnt_o}, {27'd0, g.fc});
    chk("bubble_cnt", {27'd0, bubble_cnt_o}, {27'd0, g.bc});
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    redir_sel_i = 2'b00; br_imm_i = '0; jr_tgt_i = '0;
    #2;

    // Reset state.
    step(1, 0, 0, 2'b00, 0, 0, mk(0, 0, 0, 0, 0, 0));

    // Free run: one-cycle fetch latency.
    step(0, 0, 0, 2'b00, 0, 0, mk(1, 32'h0, 32'h4, 0, 1, 0));
    step(0, 0, 0, 2'b00, 0, 0, mk(1, 32'h4, 32'h8, 0, 2, 0));
    step(0, 0, 0, 2'b00, 0, 0, mk(1, 32'h8, 32'hC, 0, 3, 0));

    // Stall three cycles with id_pc = 0x8: everything holds.
    repeat (3) step(0, 1, 0, 2'b00, 0, 0, mk(1, 32'h8, 32'hC, 0, 3, 0));
    step(0, 0, 0, 2'b00, 0, 0, mk(1, 32'hC, 32'h10, 0, 4, 0));
    step(0, 0, 0, 2'b00, 0, 0, mk(1, 32'h10, 32'h14, 0, 5, 0));

    // Taken branch from id_pc 0x10, offset -4 words: 0x14 - 0x10 = 0x4.
    step(0, 0, 0, 2'b01, 32'hFFFF_FFFC, 0, mk(0, 0, 32'h4, 0, 5, 1));
    step(0, 0, 0, 2'b00, 0, 0, mk(1, 32'h4, 32'h8, 0, 6, 1));

    // Run up to the jal at 0x20 (link value 0x24).
    for (int k = 0; k < 6; k++)
      step(0, 0, 0, 2'b00, 0, 0, mk(1, 32'h8 + 4*k, 32'hC + 4*k, 0, 7 + k, 1));
    step(0, 0, 0, 2'b00, 0, 0, mk(1, 32'h20, 32'h24, 0, 13, 1));

    // j/jal to index 0x40 -> 0x100.
    step(0, 0, 0, 2'b10, 0, 0, mk(0, 0, 32'h100, 0, 13, 2));
    step(0, 0, 0, 2'b00, 0, 0, mk(1, 32'h100, 32'h104, 0, 14, 2));

    // jr to 0x203: target forced to 0x200, misalign sets.
    step(0, 0, 0, 2'b11, 0, 32'h0000_0203, mk(0, 0, 32'h200, 1, 14, 3));
    for (int k = 0; k < 10; k++)
      step(0, 0, 0, 2'b00, 0, 0, mk(1, 32'h200 + 4*k, 32'h204 + 4*k, 1, 15 + k, 3));

    // Stall with redirect and flush: all ignored.
    step(0, 1, 1, 2'b01, 32'h0, 0, mk(1, 32'h224, 32'h228, 1, 24, 3));
    // Stall drops: redirect taken (0x228 + 4), flush adds no extra bubble.
    step(0, 0, 1, 2'b01, 32'h1, 0, mk(0, 0, 32'h22C, 1, 24, 4));
    // Redirect while ID holds a bubble: ignored.
    step(0, 0, 0, 2'b10, 0, 0, mk(1, 32'h22C, 32'h230, 1, 25, 4));
    // Plain flush: PC advances, bubble inserted.
    step(0, 0, 1, 2'b00, 0, 0, mk(0, 0, 32'h234, 1, 25, 5));
    step(0, 0, 0, 2'b00, 0, 0, mk(1, 32'h234, 32'h238, 1, 26, 5));

    // Reset during a stall (with a jr presented) discards everything.
    step(0, 1, 0, 2'b00, 0, 0, mk(1, 32'h234, 32'h238, 1, 26, 5));
    step(1, 1, 0, 2'b11, 0, 32'h0000_0203, mk(0, 0, 32'h0, 0, 0, 0));

    // Free run past fetch counter saturation (31 for a 5-bit counter).
    for (int k = 0; k < 34; k++)
      step(0, 0, 0, 2'b00, 0, 0,
           mk(1, 32'(4*k), 32'(4*k + 4), 0, (k + 1 > 31) ? 31 : k + 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_if_stage_p
